// File: rtl/hood_mode_ctrl_gen_if.sv
// Button-layer requests in, display/fan-drive status out, for the range-hood mode controller.
interface hood_mode_ctrl_gen_if #(
  parameter int unsigned NUM_LEVELS = 2,
  parameter int unsigned SEC_W      = 16
);
  logic                  pwr_short;
  logic                  pwr_long;
  logic [NUM_LEVELS-1:0] level_req;
  logic                  boost_req;
  logic                  clean_req;
  logic [2:0]            state;
  logic [2:0]            level;
  logic [SEC_W-1:0]      countdown_sec;
  logic                  boost_used;
  logic                  fan_on;

  modport master (
    output pwr_short, pwr_long, level_req, boost_req, clean_req,
    input  state, level, countdown_sec, boost_used, fan_on
  );

  modport slave (
    input  pwr_short, pwr_long, level_req, boost_req, clean_req,
    output state, level, countdown_sec, boost_used, fan_on
  );
endinterface

// File: rtl/hood_mode_ctrl_gen.sv
// Range-hood mode FSM: N fan levels, one-shot boost, timed self-clean and timed exit-to-standby.
// The shared seconds timer is a CLK_FREQ prescaler feeding a whole-second countdown.
module hood_mode_ctrl_gen #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned NUM_LEVELS = 2,
  parameter int unsigned BOOST_SEC  = 10,
  parameter int unsigned CLEAN_SEC  = 65,
  parameter int unsigned EXIT_SEC   = 10,
  parameter int unsigned SEC_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hood_mode_ctrl_gen_if.slave  bus
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [SEC_W-1:0] BOOST_T   = SEC_W'(BOOST_SEC);
  localparam logic [SEC_W-1:0] CLEAN_T   = SEC_W'(CLEAN_SEC);
  localparam logic [SEC_W-1:0] EXIT_T    = SEC_W'(EXIT_SEC);
  localparam logic [2:0]       TOP_LEVEL = 3'(NUM_LEVELS - 1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_STANDBY   = 3'd1,
    S_MENU      = 3'd2,
    S_RUN       = 3'd3,
    S_BOOST     = 3'd4,
    S_CLEAN     = 3'd5,
    S_EXIT_WAIT = 3'd6
  } state_e;

  // Held as a raw code so the unused encoding 7 stays representable and recoverable.
  logic [2:0]       state_q;
  logic [2:0]       level_q;
  logic [SEC_W-1:0] cnt_q;
  logic [PW-1:0]    presc_q;
  logic             boost_used_q;
  logic             fan_on_q;

  logic [2:0]       lvl_d;
  logic             tick_d;
  logic             expire_d;
  logic             boost_ok_d;
  logic             timed_d;

  // Lowest set request bit wins.
  always_comb begin
    lvl_d = '0;
    for (int unsigned i = NUM_LEVELS; i > 0; i--) begin
      if (bus.level_req[i-1]) lvl_d = 3'(i - 1);
    end
  end

  always_comb begin
    tick_d     = (presc_q == PRESC_MAX);
    expire_d   = tick_d && (cnt_q == SEC_W'(1));
    boost_ok_d = bus.boost_req && !boost_used_q;
    timed_d    = (state_q == S_BOOST) || (state_q == S_CLEAN) || (state_q == S_EXIT_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      level_q      <= '0;
      cnt_q        <= '0;
      presc_q      <= '0;
      boost_used_q <= 1'b0;
      fan_on_q     <= 1'b0;
    end else if (bus.pwr_long && (state_q != S_OFF)) begin
      state_q      <= S_OFF;
      cnt_q        <= '0;
      presc_q      <= '0;
      boost_used_q <= 1'b0;
      fan_on_q     <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          boost_used_q <= 1'b0;
          if (bus.pwr_short) state_q <= S_STANDBY;
        end

        S_STANDBY: begin
          if (bus.pwr_short) state_q <= S_MENU;
        end

        S_MENU: begin
          if (|bus.level_req) begin
            state_q  <= S_RUN;
            level_q  <= lvl_d;
            fan_on_q <= 1'b1;
          end else if (boost_ok_d) begin
            state_q      <= S_BOOST;
            boost_used_q <= 1'b1;
            cnt_q        <= BOOST_T;
            presc_q      <= '0;
            fan_on_q     <= 1'b1;
          end else if (bus.clean_req) begin
            state_q <= S_CLEAN;
            cnt_q   <= CLEAN_T;
            presc_q <= '0;
          end
        end

        S_RUN: begin
          if (|bus.level_req) begin
            level_q <= lvl_d;
          end else if (boost_ok_d) begin
            state_q      <= S_BOOST;
            boost_used_q <= 1'b1;
            cnt_q        <= BOOST_T;
            presc_q      <= '0;
          end else if (bus.pwr_short) begin
            state_q  <= S_STANDBY;
            fan_on_q <= 1'b0;
          end
        end

        // Expiry is checked first so it beats a same-cycle pwr_short.
        S_BOOST: begin
          if (expire_d) begin
            state_q <= S_RUN;
            level_q <= TOP_LEVEL;
            cnt_q   <= '0;
            presc_q <= '0;
          end else if (bus.pwr_short) begin
            state_q <= S_EXIT_WAIT;
            cnt_q   <= EXIT_T;
            presc_q <= '0;
          end else begin
            presc_q <= tick_d ? '0 : presc_q + PW'(1);
            if (tick_d) cnt_q <= cnt_q - SEC_W'(1);
          end
        end

        S_CLEAN, S_EXIT_WAIT: begin
          if (expire_d) begin
            state_q  <= S_STANDBY;
            cnt_q    <= '0;
            presc_q  <= '0;
            fan_on_q <= 1'b0;
          end else begin
            presc_q <= tick_d ? '0 : presc_q + PW'(1);
            if (tick_d) cnt_q <= cnt_q - SEC_W'(1);
          end
        end

        default: begin
          state_q  <= S_STANDBY;
          cnt_q    <= '0;
          presc_q  <= '0;
          fan_on_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state         = state_q;
  assign bus.level         = level_q;
  assign bus.countdown_sec = cnt_q;
  assign bus.boost_used    = boost_used_q;
  assign bus.fan_on        = fan_on_q;

  a_idle_timer_clear: assert property (@(posedge clk) disable iff (!rst_n)
    !timed_d |-> (cnt_q == '0) && (presc_q == '0));

  a_timed_count_live: assert property (@(posedge clk) disable iff (!rst_n)
    timed_d |-> (cnt_q != '0));

  a_boost_marks_used: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_BOOST) |-> boost_used_q);

  a_fan_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != 3'd7) |->
      (fan_on_q == ((state_q == S_RUN) || (state_q == S_BOOST) || (state_q == S_EXIT_WAIT))));

endmodule

// File: tb/tb_hood_mode_ctrl_gen.sv
// Scoreboard bench for hood_mode_ctrl_gen: directed scenarios then random pulses, checked against
// a cycle-budget reference model (remaining cycles in a timed state, seconds = ceil(cycles/F)).
module tb_hood_mode_ctrl_gen;

  localparam int unsigned F  = 4;
  localparam int unsigned NL = 3;
  localparam int unsigned BS = 3;
  localparam int unsigned CS = 5;
  localparam int unsigned ES = 2;
  localparam int unsigned SW = 16;

  localparam int OFF = 0, STANDBY = 1, MENU = 2, RUN = 3, BOOST = 4, CLEAN = 5, EXITW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hood_mode_ctrl_gen_if #(.NUM_LEVELS(NL), .SEC_W(SW)) bus ();

  hood_mode_ctrl_gen #(
    .CLK_FREQ  (F),
    .NUM_LEVELS(NL),
    .BOOST_SEC (BS),
    .CLEAN_SEC (CS),
    .EXIT_SEC  (ES),
    .SEC_W     (SW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int st;
    int lvl;
    int cd;
    bit used;
    bit fan;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  int m_st, m_lvl, m_rem;
  bit m_used;

  function automatic int dur(int st);
    if (st == BOOST) return BS * F;
    if (st == CLEAN) return CS * F;
    return ES * F;
  endfunction

  function automatic bit timed(int st);
    return (st == BOOST) || (st == CLEAN) || (st == EXITW);
  endfunction

  function automatic int lowest(logic [NL-1:0] lr);
    for (int i = 0; i < NL; i++) if (lr[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = OFF; m_lvl = 0; m_rem = 0; m_used = 1'b0;
  endtask

  task automatic model_step(bit ps, bit pl, logic [NL-1:0] lr, bit br, bit cr);
    int nxt;
    nxt = m_st;
    if (pl && m_st != OFF) begin
      nxt = OFF;
      m_used = 1'b0;
    end else begin
      case (m_st)
        OFF:     begin m_used = 1'b0; if (ps) nxt = STANDBY; end
        STANDBY: if (ps) nxt = MENU;
        MENU: begin
          if (lr != 0) begin nxt = RUN; m_lvl = lowest(lr); end
          else if (br && !m_used) nxt = BOOST;
          else if (cr) nxt = CLEAN;
        end
        RUN: begin
          if (lr != 0) m_lvl = lowest(lr);
          else if (br && !m_used) nxt = BOOST;
          else if (ps) nxt = STANDBY;
        end
        BOOST: begin
          if (m_rem == 1) begin nxt = RUN; m_lvl = NL - 1; end
          else if (ps) nxt = EXITW;
        end
        CLEAN, EXITW: if (m_rem == 1) nxt = STANDBY;
        default: nxt = STANDBY;
      endcase
    end
    if (nxt == BOOST && m_st != BOOST) m_used = 1'b1;
    if (timed(nxt)) m_rem = (nxt != m_st) ? dur(nxt) : m_rem - 1;
    else m_rem = 0;
    m_st = nxt;
  endtask

  task automatic push_expected();
    exp_t e;
    e.st   = m_st;
    e.lvl  = m_lvl;
    e.cd   = timed(m_st) ? (m_rem + F - 1) / F : 0;
    e.used = m_used;
    e.fan  = (m_st == RUN) || (m_st == BOOST) || (m_st == EXITW);
    sbq.push_back(e);
  endtask

  task automatic drive(bit ps, bit pl, logic [NL-1:0] lr, bit br, bit cr);
    bus.pwr_short = ps;
    bus.pwr_long  = pl;
    bus.level_req = lr;
    bus.boost_req = br;
    bus.clean_req = cr;
  endtask

  task automatic cyc(bit ps, bit pl, logic [NL-1:0] lr, bit br, bit cr);
    @(negedge clk);
    rst_n = 1'b1;
    drive(ps, pl, lr, br, cr);
    model_step(ps, pl, lr, br, cr);
    push_expected();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0);
    model_reset();
    push_expected();
  endtask

  // Corrupt the state register to the unused code for one half-cycle.
  task automatic force_illegal();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, '0, 0, 0);
    force dut.state_q = 3'd7;
    #1 release dut.state_q;
    m_st = 7;
    m_rem = 0;
    model_step(0, 0, '0, 0, 0);
    push_expected();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (bus.state !== 3'(e.st) || bus.level !== 3'(e.lvl) ||
            bus.countdown_sec !== SW'(e.cd) || bus.boost_used !== e.used ||
            bus.fan_on !== e.fan) begin
          errors++;
          $display("FAIL outputs @%0t: state got %0d exp %0d, level got %0d exp %0d, countdown got %0d exp %0d, boost_used got %0b exp %0b, fan_on got %0b exp %0b",
                   $time, bus.state, e.st, bus.level, e.lvl, bus.countdown_sec, e.cd,
                   bus.boost_used, e.used, bus.fan_on, e.fan);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached, bench did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    drive(0, 0, '0, 0, 0);
    model_reset();

    // 1: reset mid-BOOST, then power up into RUN level 1
    do_reset();
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, 3'b110, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 1, 0);
    idle(5);
    do_reset();
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, 3'b110, 0, 0);

    // 2: full BOOST to expiry, second boost ignored
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 1, 0);
    idle(12);
    cyc(0, 0, '0, 1, 0);
    idle(2);

    // 3: early exit from BOOST into EXIT_WAIT, level_req ignored there
    cyc(0, 1, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 1, 0);
    idle(4);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, 3'b001, 0, 0);
    idle(8);

    // 4: CLEAN ignores pwr_short; second CLEAN aborted by pwr_long
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 1);
    idle(9);
    cyc(1, 0, '0, 0, 0);
    idle(12);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 1);
    idle(9);
    cyc(0, 1, '0, 0, 0);
    idle(2);

    // 5: expiry coincides with pwr_short; boost re-allowed after OFF
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 1, 0);
    idle(11);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 1, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 1, 0);
    idle(3);
    cyc(0, 1, '0, 0, 0);

    // 6: illegal code recovery, STANDBY ignores requests
    cyc(1, 0, '0, 0, 0);
    force_illegal();
    cyc(0, 0, 3'b111, 0, 0);
    cyc(0, 0, '0, 1, 0);
    cyc(0, 0, '0, 0, 1);
    idle(2);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, 3'b001, 0, 0);
    force_illegal();
    idle(2);

    // Random pulses
    for (int n = 0; n < 3000; n++) begin
      bit ps, pl, br, cr;
      logic [NL-1:0] lr;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        ps = ($urandom_range(0, 5) == 0);
        pl = ($urandom_range(0, 59) == 0);
        br = ($urandom_range(0, 7) == 0);
        cr = ($urandom_range(0, 7) == 0);
        lr = ($urandom_range(0, 7) == 0) ? NL'($urandom_range(1, 7)) : '0;
        cyc(ps, pl, lr, br, cr);
      end
    end

    @(negedge clk);
    drive(0, 0, '0, 0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
